// File: rtl/l2_access_sequencer.sv
// l2_access_sequencer: per-request L2 controller sequencing lookup, victim writeback, bus fill and MESI/LRU commit
// Optional statistics counters are enabled by defining L2_STATS_EN.
module l2_access_sequencer #(
  parameter int ADDR_W = 32,
  parameter int INDEX_W = 14,
  parameter int TAG_W = 12,
  parameter int WAYS = 8,
  parameter int STAT_W = 32,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic rsp_valid,
  output logic rsp_hit,
  output logic [INDEX_W-1:0] arr_index,
  output logic [TAG_W-1:0] arr_tag,
  output logic arr_lookup,
  input  logic arr_hit,
  input  logic [WAY_W-1:0] arr_hit_way,
  input  logic [3:0] arr_hit_mesi,
  input  logic [WAY_W-1:0] arr_victim_way,
  input  logic [TAG_W-1:0] arr_victim_tag,
  input  logic [3:0] arr_victim_mesi,
  output logic arr_update,
  output logic [WAY_W-1:0] arr_update_way,
  output logic [TAG_W-1:0] arr_update_tag,
  output logic [3:0] arr_update_mesi,
  output logic bus_req_valid,
  output logic [1:0] bus_req_op,
  output logic [ADDR_W-1:0] bus_req_addr,
  input  logic bus_ack,
  input  logic bus_shared,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses,
  output logic [STAT_W-1:0] stat_writebacks
);
  localparam int OFF_W = ADDR_W - INDEX_W - TAG_W;
  localparam logic [3:0] MESI_S = 4'b0010, MESI_E = 4'b0100, MESI_M = 4'b1000;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, UPGRADE, UPDATE, RESPOND} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic wr;
  logic hit;
  logic [WAY_W-1:0] way;
  logic [3:0] mesi;
  logic [ADDR_W-1:0] line_addr;
  assign line_addr = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign arr_index = addr[OFF_W +: INDEX_W];
  assign arr_tag = addr[ADDR_W-1 -: TAG_W];
  assign req_ready = state == IDLE;
  assign arr_update_way = way;
  assign arr_update_tag = arr_tag;
  assign arr_update_mesi = mesi;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      wr <= 1'b0;
      hit <= 1'b0;
      way <= '0;
      mesi <= '0;
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      arr_lookup <= 1'b0;
      arr_update <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_op <= 2'b00;
      bus_req_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      arr_lookup <= 1'b0;
      arr_update <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          addr <= req_addr;
          wr <= req_write;
          arr_lookup <= 1'b1;
          state <= LOOKUP;
        end
        LOOKUP: begin
          hit <= arr_hit;
          way <= arr_hit ? arr_hit_way : arr_victim_way;
          if (arr_hit && wr && arr_hit_mesi == MESI_S) begin
            bus_req_valid <= 1'b1;
            bus_req_op <= 2'b10;
            bus_req_addr <= line_addr;
            state <= UPGRADE;
          end else if (arr_hit) begin
            mesi <= wr ? MESI_M : arr_hit_mesi;
            arr_update <= 1'b1;
            state <= UPDATE;
          end else if (arr_victim_mesi == MESI_M) begin
            bus_req_valid <= 1'b1;
            bus_req_op <= 2'b11;
            bus_req_addr <= {arr_victim_tag, arr_index, {OFF_W{1'b0}}};
            state <= WRITEBACK;
          end else begin
            bus_req_valid <= 1'b1;
            bus_req_op <= {1'b0, wr};
            bus_req_addr <= line_addr;
            state <= FILL;
          end
        end
        // Drop valid for a cycle between the writeback and the fill so each op is distinct.
        WRITEBACK: if (bus_req_valid && bus_ack) begin
          bus_req_valid <= 1'b0;
          bus_req_op <= {1'b0, wr};
          bus_req_addr <= line_addr;
          state <= FILL;
        end
        FILL: if (!bus_req_valid) bus_req_valid <= 1'b1;
        else if (bus_ack) begin
          bus_req_valid <= 1'b0;
          mesi <= wr ? MESI_M : (bus_shared ? MESI_S : MESI_E);
          arr_update <= 1'b1;
          state <= UPDATE;
        end
        UPGRADE: if (bus_req_valid && bus_ack) begin
          bus_req_valid <= 1'b0;
          mesi <= MESI_M;
          arr_update <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: begin
          rsp_valid <= 1'b1;
          rsp_hit <= hit;
          state <= RESPOND;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef L2_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits <= '0;
      stat_misses <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == LOOKUP && arr_hit) stat_hits <= stat_hits + STAT_W'(~&stat_hits);
      if (state == LOOKUP && !arr_hit) stat_misses <= stat_misses + STAT_W'(~&stat_misses);
      if (state == WRITEBACK && bus_req_valid && bus_ack)
        stat_writebacks <= stat_writebacks + STAT_W'(~&stat_writebacks);
    end
  end
`else
  assign stat_hits = '0;
  assign stat_misses = '0;
  assign stat_writebacks = '0;
`endif
endmodule

// File: tb/tb_l2_access_sequencer.sv
// tb_l2_access_sequencer: directed scenarios for the L2 access sequencer
module tb_l2_access_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic rsp_valid, rsp_hit;
  logic [13:0] arr_index;
  logic [11:0] arr_tag;
  logic arr_lookup;
  logic arr_hit = 1'b0;
  logic [2:0] arr_hit_way = '0;
  logic [3:0] arr_hit_mesi = 4'b0001;
  logic [2:0] arr_victim_way = '0;
  logic [11:0] arr_victim_tag = '0;
  logic [3:0] arr_victim_mesi = 4'b0001;
  logic arr_update;
  logic [2:0] arr_update_way;
  logic [11:0] arr_update_tag;
  logic [3:0] arr_update_mesi;
  logic bus_req_valid;
  logic [1:0] bus_req_op;
  logic [31:0] bus_req_addr;
  logic bus_ack = 1'b0;
  logic bus_shared = 1'b0;
  logic [31:0] stat_hits, stat_misses, stat_writebacks;

  l2_access_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .arr_index(arr_index), .arr_tag(arr_tag), .arr_lookup(arr_lookup), .arr_hit(arr_hit),
    .arr_hit_way(arr_hit_way), .arr_hit_mesi(arr_hit_mesi), .arr_victim_way(arr_victim_way),
    .arr_victim_tag(arr_victim_tag), .arr_victim_mesi(arr_victim_mesi), .arr_update(arr_update),
    .arr_update_way(arr_update_way), .arr_update_tag(arr_update_tag),
    .arr_update_mesi(arr_update_mesi), .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op),
    .bus_req_addr(bus_req_addr), .bus_ack(bus_ack), .bus_shared(bus_shared),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: acks ack_delay cycles after bus_req_valid is seen high.
  int ack_delay = 0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!bus_req_valid || bus_ack) begin
      bus_ack = 1'b0;
      ack_cnt = 0;
    end else if (ack_cnt >= ack_delay) bus_ack = 1'b1;
    else ack_cnt++;
  end

  // Recorder of DUT output events, sampled mid-cycle.
  int n_upd = 0, n_rsp = 0, n_ops = 0, n_rise = 0, rsp_edge = 0;
  logic [2:0] upd_way;
  logic [3:0] upd_mesi;
  logic [11:0] upd_tag;
  logic rsp_hit_s;
  logic prev_bv = 1'b0;
  logic [1:0] ops[32];
  logic [31:0] addrs[32];
  always @(negedge clk) begin
    if (arr_update) begin
      n_upd++;
      upd_way = arr_update_way;
      upd_mesi = arr_update_mesi;
      upd_tag = arr_update_tag;
    end
    if (rsp_valid) begin
      n_rsp++;
      rsp_hit_s = rsp_hit;
      rsp_edge = cyc + 1;
    end
    if (bus_req_valid && !prev_bv) n_rise++;
    prev_bv = bus_req_valid;
    if (bus_req_valid && bus_ack && n_ops < 32) begin
      ops[n_ops] = bus_req_op;
      addrs[n_ops] = bus_req_addr;
      n_ops++;
    end
  end

  int b_upd, b_rsp, b_ops, b_rise, acc, lat;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input logic w, input logic [31:0] a);
    b_upd = n_upd; b_rsp = n_rsp; b_ops = n_ops; b_rise = n_rise;
    req_valid = 1'b1; req_write = w; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    for (int i = 0; i < 60 && n_rsp == b_rsp; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (n_rsp != b_rsp + 1) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses want 1", n_rsp - b_rsp);
    end
    lat = rsp_edge - acc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_hit, arr_lookup, arr_update, bus_req_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {req_ready, rsp_valid, rsp_hit, arr_lookup, arr_update, bus_req_valid});
    end
    checks++;
    if ({bus_req_op, bus_req_addr, arr_tag, arr_index, arr_update_mesi} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got op=%b addr=%h tag=%h idx=%h mesi=%b want all 0",
               bus_req_op, bus_req_addr, arr_tag, arr_index, arr_update_mesi);
    end
    checks++;
    if ({stat_hits, stat_misses, stat_writebacks} !== '0) begin
      errors++;
      $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_hits, stat_misses, stat_writebacks);
    end
  endtask

  task automatic test_read_hit();
    arr_hit = 1'b1; arr_hit_way = 3'd3; arr_hit_mesi = 4'b0100;
    arr_victim_way = 3'd6; arr_victim_mesi = 4'b1000; arr_victim_tag = 12'hFFF;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00401040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({arr_lookup, req_ready, arr_tag, arr_index} !== {1'b1, 1'b0, 12'h004, 14'h0041}) begin
      errors++;
      $display("FAIL lookup_fields: got lk=%b rdy=%b tag=%h idx=%h want 1 0 004 0041",
               arr_lookup, req_ready, arr_tag, arr_index);
    end
    repeat (3) @(posedge clk);
    #1;
    b_upd = n_upd; b_ops = n_ops;
    run(1'b0, 32'h00401040);
    checks++;
    if ({upd_way, upd_mesi, upd_tag} !== {3'd3, 4'b0100, 12'h004} || n_upd != b_upd + 1) begin
      errors++;
      $display("FAIL read_hit_update: got way=%0d mesi=%b tag=%h n=%0d want 3 0100 004 1",
               upd_way, upd_mesi, upd_tag, n_upd - b_upd);
    end
    checks++;
    if (rsp_hit_s !== 1'b1 || lat != 3) begin
      errors++;
      $display("FAIL read_hit_rsp: got hit=%b lat=%0d want 1 3", rsp_hit_s, lat);
    end
    checks++;
    if (n_rise != b_rise) begin
      errors++;
      $display("FAIL read_hit_bus: got %0d bus requests want 0", n_rise - b_rise);
    end
  endtask

  task automatic test_write_miss_dirty();
    arr_hit = 1'b0; arr_victim_way = 3'd5; arr_victim_mesi = 4'b1000; arr_victim_tag = 12'h123;
    ack_delay = 1;
    run(1'b1, 32'h00ABCDC0);
    checks++;
    if (n_ops != b_ops + 2 || n_rise != b_rise + 2) begin
      errors++;
      $display("FAIL wm_op_count: got ops=%0d rises=%0d want 2 2", n_ops - b_ops, n_rise - b_rise);
    end
    checks++;
    if (ops[b_ops] !== 2'b11 || addrs[b_ops] !== 32'h123BCDC0) begin
      errors++;
      $display("FAIL wm_writeback: got op=%b addr=%h want 11 123bcdc0", ops[b_ops], addrs[b_ops]);
    end
    checks++;
    if (ops[b_ops+1] !== 2'b01 || addrs[b_ops+1] !== 32'h00ABCDC0) begin
      errors++;
      $display("FAIL wm_rfo: got op=%b addr=%h want 01 00abcdc0", ops[b_ops+1], addrs[b_ops+1]);
    end
    checks++;
    if ({upd_way, upd_mesi, upd_tag, rsp_hit_s} !== {3'd5, 4'b1000, 12'h00A, 1'b0}) begin
      errors++;
      $display("FAIL wm_update: got way=%0d mesi=%b tag=%h hit=%b want 5 1000 00a 0",
               upd_way, upd_mesi, upd_tag, rsp_hit_s);
    end
  endtask

  task automatic test_read_miss_shared();
    arr_hit = 1'b0; arr_victim_way = 3'd2; arr_victim_mesi = 4'b0010; arr_victim_tag = 12'h555;
    bus_shared = 1'b1; ack_delay = 4;
    run(1'b0, 32'h7FF00FC0);
    checks++;
    if (n_ops != b_ops + 1 || ops[b_ops] !== 2'b00 || addrs[b_ops] !== 32'h7FF00FC0) begin
      errors++;
      $display("FAIL rm_read: got n=%0d op=%b addr=%h want 1 00 7ff00fc0",
               n_ops - b_ops, ops[b_ops], addrs[b_ops]);
    end
    checks++;
    if ({upd_way, upd_mesi, rsp_hit_s} !== {3'd2, 4'b0010, 1'b0} || lat <= 3) begin
      errors++;
      $display("FAIL rm_update: got way=%0d mesi=%b hit=%b lat=%0d want 2 0010 0 >3",
               upd_way, upd_mesi, rsp_hit_s, lat);
    end
    bus_shared = 1'b0; ack_delay = 0;
    run(1'b0, 32'h7FF00FC0);
    checks++;
    if (upd_mesi !== 4'b0100 || ops[b_ops] !== 2'b00) begin
      errors++;
      $display("FAIL rm_exclusive: got mesi=%b op=%b want 0100 00", upd_mesi, ops[b_ops]);
    end
  endtask

  task automatic test_write_hit_shared();
    arr_hit = 1'b1; arr_hit_way = 3'd1; arr_hit_mesi = 4'b0010;
    arr_victim_way = 3'd7; arr_victim_mesi = 4'b1000;
    ack_delay = 0;
    run(1'b1, 32'h00C00080);
    checks++;
    if (n_ops != b_ops + 1 || ops[b_ops] !== 2'b10 || addrs[b_ops] !== 32'h00C00080) begin
      errors++;
      $display("FAIL upg_op: got n=%0d op=%b addr=%h want 1 10 00c00080",
               n_ops - b_ops, ops[b_ops], addrs[b_ops]);
    end
    checks++;
    if ({upd_way, upd_mesi, rsp_hit_s} !== {3'd1, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL upg_update: got way=%0d mesi=%b hit=%b want 1 1000 1", upd_way, upd_mesi, rsp_hit_s);
    end
    arr_hit_mesi = 4'b0100;
    run(1'b1, 32'h00C00080);
    checks++;
    if (n_rise != b_rise || upd_mesi !== 4'b1000 || lat != 3) begin
      errors++;
      $display("FAIL wr_hit_e: got bus=%0d mesi=%b lat=%0d want 0 1000 3", n_rise - b_rise, upd_mesi, lat);
    end
  endtask

  task automatic test_reset_in_fill();
    arr_hit = 1'b0; arr_victim_way = 3'd4; arr_victim_mesi = 4'b0100;
    ack_delay = 1000;
    b_upd = n_upd; b_rsp = n_rsp;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h01234540;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !bus_req_valid; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus_req_valid !== 1'b1 || bus_req_op !== 2'b00) begin
      errors++;
      $display("FAIL rf_fill_pending: got v=%b op=%b want 1 00", bus_req_valid, bus_req_op);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, bus_req_valid, arr_update, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL rf_after_reset: got %b want 1000", {req_ready, bus_req_valid, arr_update, rsp_valid});
    end
    reset = 1'b0;
    ack_delay = 0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_upd != b_upd || n_rsp != b_rsp || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rf_abandoned: got upd=%0d rsp=%0d rdy=%b want 0 0 1", n_upd - b_upd, n_rsp - b_rsp, req_ready);
    end
  endtask

  task automatic test_stats();
    int eh, em, ew;
`ifdef L2_STATS_EN
    eh = 2; em = 1; ew = 1;
`else
    eh = 0; em = 0; ew = 0;
`endif
    do_reset();
    arr_hit = 1'b1; arr_hit_way = 3'd0; arr_hit_mesi = 4'b0100;
    run(1'b0, 32'h00000040);
    run(1'b0, 32'h00000080);
    arr_hit = 1'b0; arr_victim_mesi = 4'b1000; arr_victim_tag = 12'h0AA; ack_delay = 2;
    run(1'b1, 32'h00100100);
    checks++;
    if (stat_hits != 32'(eh) || stat_misses != 32'(em) || stat_writebacks != 32'(ew)) begin
      errors++;
      $display("FAIL stats: got %0d %0d %0d want %0d %0d %0d",
               stat_hits, stat_misses, stat_writebacks, eh, em, ew);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_miss_dirty();
    test_read_miss_shared();
    test_write_hit_shared();
    test_reset_in_fill();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
